// File: rtl/arb_req_client.sv
// arb_req_client
// Requester-side front end for one port of a two-way req/gnt arbiter.
// Burst commands (a beat count each) are queued in a small FIFO. Each
// command is popped in IDLE, raises req, waits for gnt, then issues
// cmd_len data beats. It then drops req and waits for gnt to fall before
// the next command can start.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         asynchronous, active-high reset
//   i_cmd_valid   command offered
//   i_cmd_len     burst length in beats (0 = complete immediately, no req)
//   o_cmd_ready   FIFO can accept a command (not full)
//   o_req         registered request to the arbiter
//   i_gnt         grant from the arbiter (registered on its side)
//   o_beat_valid  a data beat occurs this cycle
//   o_beat_cnt    beats remaining, including the current one
//   o_busy        FSM is not idle
//   o_done        one-cycle pulse when a burst fully completes
module arb_req_client #(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [LEN_W-1:0] i_cmd_len,
  output logic             o_cmd_ready,
  output logic             o_req,
  input  logic             i_gnt,
  output logic             o_beat_valid,
  output logic [LEN_W-1:0] o_beat_cnt,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  // Command storage; only the pointers and count need reset
  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic [1:0]       r_state;
  logic             r_req;
  logic [LEN_W-1:0] r_beat_cnt;
  logic             r_done;

  logic             w_push;
  logic             w_pop;
  logic [LEN_W-1:0] w_head;
  logic             w_beat;
  logic             w_last;

  assign o_cmd_ready  = (r_count != CNT_FULL);
  assign w_push       = i_cmd_valid & o_cmd_ready;
  // Head is read directly so a command pushed into an empty FIFO
  // can be popped on the very next cycle.
  assign w_pop        = (r_state == S_IDLE) & (r_count != '0);
  assign w_head       = r_mem[r_rd_ptr];
  // Losing gnt mid-burst stalls the transfer without counting a beat
  assign w_beat       = (r_state == S_XFER) & i_gnt;
  assign w_last       = w_beat & (r_beat_cnt == LEN_ONE);

  assign o_req        = r_req;
  assign o_beat_valid = w_beat;
  assign o_beat_cnt   = r_beat_cnt;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_cmd_len;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head == '0) begin
              // Zero-length burst completes without touching the arbiter
              r_done <= 1'b1;
            end else begin
              r_beat_cnt <= w_head;
              r_req      <= 1'b1;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_gnt) begin
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_last) begin
            r_req      <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_RELEASE;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt - LEN_ONE;
          end
        end
        S_RELEASE: begin
          // Wait for the arbiter to withdraw gnt so the next req can never
          // overlap the previous grant.
          if (!i_gnt) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_req_client.sv
module tb_arb_req_client;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       cmd_valid  [2];
  logic [3:0] cmd_len    [2];
  logic       cmd_ready  [2];
  logic       req        [2];
  logic       gnt_arb    [2];
  logic       gnt        [2];
  logic       beat_valid [2];
  logic [3:0] beat_cnt   [2];
  logic       busy       [2];
  logic       done       [2];

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected burst lengths per port, in push order
  int sbq [2][$];
  int cur [2];

  typedef struct {
    logic [1:0] ports;
    logic [3:0] len;
    logic       exp_ready;
  } vec_t;
  vec_t vt [14];

  always #5 clk = ~clk;

  arb_req_client #(.LEN_W(4), .DEPTH(4), .AW(2)) u0 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid[0]), .i_cmd_len(cmd_len[0]),
    .o_cmd_ready(cmd_ready[0]), .o_req(req[0]), .i_gnt(gnt[0]),
    .o_beat_valid(beat_valid[0]), .o_beat_cnt(beat_cnt[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  arb_req_client #(.LEN_W(4), .DEPTH(4), .AW(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid[1]), .i_cmd_len(cmd_len[1]),
    .o_cmd_ready(cmd_ready[1]), .o_req(req[1]), .i_gnt(gnt[1]),
    .o_beat_valid(beat_valid[1]), .o_beat_cnt(beat_cnt[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  // Two-way arbiter model: registered grant, port 0 priority, grant held
  // while req stays high, one idle edge between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_arb[0] <= 1'b0;
      gnt_arb[1] <= 1'b0;
    end else if (gnt_arb[0]) begin
      if (!req[0]) gnt_arb[0] <= 1'b0;
    end else if (gnt_arb[1]) begin
      if (!req[1]) gnt_arb[1] <= 1'b0;
    end else if (req[0]) begin
      gnt_arb[0] <= 1'b1;
    end else if (req[1]) begin
      gnt_arb[1] <= 1'b1;
    end
  end

  assign gnt[0] = gnt_arb[0] & ~stall;
  assign gnt[1] = gnt_arb[1];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare beats and done pulses against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      cur[0] = 0;
      cur[1] = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (beat_valid[p]) begin
          if (sbq[p].size() == 0) begin
            check($sformatf("p%0d_unexpected_beat", p), 1, 0);
          end else begin
            check($sformatf("p%0d_beat_cnt", p), beat_cnt[p], sbq[p][0] - cur[p]);
            cur[p]++;
          end
        end
        if (done[p]) begin
          if (sbq[p].size() == 0) begin
            check($sformatf("p%0d_unexpected_done", p), 1, 0);
          end else begin
            check($sformatf("p%0d_beats_per_burst", p), cur[p], sbq[p][0]);
            check($sformatf("p%0d_req_low_at_done", p), req[p], 0);
            void'(sbq[p].pop_front());
          end
          cur[p] = 0;
        end
      end
      if (beat_valid[0] || beat_valid[1]) begin
        check("beat_overlap", beat_valid[0] & beat_valid[1], 0);
      end
    end
  end

  // Drive table rows lo..hi on consecutive cycles
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (vt[i].ports[p]) begin
          check($sformatf("p%0d_cmd_ready_row%0d", p, i), cmd_ready[p], vt[i].exp_ready);
          cmd_valid[p] = 1'b1;
          cmd_len[p]   = vt[i].len;
          if (vt[i].exp_ready) sbq[p].push_back(int'(vt[i].len));
        end else begin
          cmd_valid[p] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    cmd_valid[1] = 1'b0;
  endtask

  function automatic bit all_idle();
    return (sbq[0].size() == 0) && (sbq[1].size() == 0) && !busy[0] && !busy[1];
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!all_idle() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle_timeout"}, all_idle(), 1);
  endtask

  initial begin
    int n;
    int dones;

    vt[0]  = '{2'b01, 4'd3, 1'b1};   // basic burst
    vt[1]  = '{2'b01, 4'd1, 1'b1};   // held in REQ so the FIFO can fill
    vt[2]  = '{2'b01, 4'd1, 1'b1};
    vt[3]  = '{2'b01, 4'd2, 1'b1};
    vt[4]  = '{2'b01, 4'd1, 1'b1};
    vt[5]  = '{2'b01, 4'd2, 1'b1};
    vt[6]  = '{2'b01, 4'd3, 1'b0};   // refused: FIFO full
    vt[7]  = '{2'b01, 4'd0, 1'b1};   // zero length
    vt[8]  = '{2'b01, 4'd2, 1'b1};
    vt[9]  = '{2'b01, 4'd5, 1'b1};   // stall test
    vt[10] = '{2'b01, 4'd4, 1'b1};   // reset test
    vt[11] = '{2'b01, 4'd2, 1'b1};
    vt[12] = '{2'b01, 4'd3, 1'b1};
    vt[13] = '{2'b11, 4'd2, 1'b1};   // both ports

    rst = 1'b1;
    stall = 1'b0;
    cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
    cmd_len[0] = '0;     cmd_len[1] = '0;
    cur[0] = 0;          cur[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_cmd_ready", cmd_ready[0], 1);
    check("rst_req", req[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_beat_cnt", beat_cnt[0], 0);
    check("rst_beat_valid", beat_valid[0], 0);
    check("rst_p1_req", req[1], 0);

    // 1: single len=3 burst, latency from empty
    apply(0, 0);
    check("t1_req_after_push_edge", req[0], 0);
    @(posedge clk); #1;
    check("t1_req_one_cycle_later", req[0], 1);
    check("t1_busy", busy[0], 1);
    @(posedge clk); #1;
    check("t1_no_beat_in_req", beat_valid[0], 0);
    wait_idle("t1");

    // 2: fill the FIFO behind a burst stuck in REQ
    stall = 1'b1;
    apply(1, 1);
    apply(2, 6);
    check("t2_ready_low_when_full", cmd_ready[0], 0);
    check("t2_req_held", req[0], 1);
    stall = 1'b0;
    wait_idle("t2");

    // 3: zero-length command, then a normal one
    apply(7, 7);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t3_no_req_len0", req[0], 0);
      if (done[0]) dones++;
    end
    check("t3_done_pulses_len0", dones, 1);
    apply(8, 8);
    wait_idle("t3");

    // 4: gnt stall mid-transfer
    apply(9, 9);
    n = 0;
    while (!(beat_valid[0] && beat_cnt[0] == 4'd4) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_reach_cnt4", n < 50, 1);
    @(posedge clk); #1;
    stall = 1'b1;
    #1;
    check("t4_stall1_beat", beat_valid[0], 0);
    check("t4_stall1_cnt", beat_cnt[0], 3);
    @(posedge clk); #1;
    check("t4_stall2_beat", beat_valid[0], 0);
    check("t4_stall2_cnt", beat_cnt[0], 3);
    @(posedge clk); #1;
    stall = 1'b0;
    #1;
    check("t4_resume_beat", beat_valid[0], 1);
    check("t4_resume_cnt", beat_cnt[0], 3);
    wait_idle("t4");

    // 5: reset during transfer with commands queued
    apply(10, 12);
    n = 0;
    while (!beat_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_reach_xfer", beat_valid[0], 1);
    rst = 1'b1;
    #1;
    check("t5_req_drop", req[0], 0);
    check("t5_beat_drop", beat_valid[0], 0);
    check("t5_busy_drop", busy[0], 0);
    sbq[0].delete();
    sbq[1].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_cmd_ready", cmd_ready[0], 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t5_no_req_after_rst", req[0], 0);
    end

    // 6: both ports push the same cycle
    apply(13, 13);
    @(posedge clk); #1;
    check("t6_req0", req[0], 1);
    check("t6_req1", req[1], 1);
    n = 0;
    while (!beat_valid[0] && !beat_valid[1] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_first_is_p0", beat_valid[0], 1);
    check("t6_p1_waiting", beat_valid[1], 0);
    check("t6_p1_req_held", req[1], 1);
    wait_idle("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
